// File: rtl/iecdrv_pkg.sv
// Shared definitions for the IEC drive block-request server.
//   state_t      : transfer state machine encoding
//   BLK_BYTES    : bytes per block
//   MAX_DRIVES   : upper bound on drive request channels
//   clamp_drives : maps the DRIVES parameter onto 1..MAX_DRIVES
package iecdrv_pkg;

    localparam int BLK_BYTES  = 512;
    localparam int MAX_DRIVES = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_LAT,
        WR_REQ,
        FINISH
    } state_t;

    function automatic int clamp_drives(input int d);
        if (d < 1)
            return 1;
        else if (d > MAX_DRIVES)
            return MAX_DRIVES;
        else
            return d;
    endfunction

endpackage

// File: rtl/iecdrv_rr_arb.sv
// Combinational round-robin picker.
//   req   : request vector, padded to MAX_DRIVES; only the low NDR bits are searched
//   ptr   : first index to consider (0..NDR-1)
//   grant : index of the first requester at or after ptr, wrapping at NDR
//   valid : at least one request among the low NDR bits
module iecdrv_rr_arb
    import iecdrv_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [MAX_DRIVES-1:0] req,
    input  logic [1:0]            ptr,
    output logic [1:0]            grant,
    output logic                  valid
);

    logic [2:0] pos;

    // Scan from the farthest offset down to ptr itself so the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        for (int off = NDR - 1; off >= 0; off--) begin
            pos = {1'b0, ptr} + 3'(off);
            if (pos >= 3'(NDR))
                pos = pos - 3'(NDR);
            if (req[pos[1:0]]) begin
                grant = pos[1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iecdrv_sd_server.sv
// Host-side responder for the per-drive block request interface.
// Grants one drive at a time (round-robin), then streams every byte of the
// multi-block transfer between the drive buffer port and a byte-wide store.
//   clk_sys, reset        : clock, synchronous active-high reset
//   sd_lba/sd_blk_cnt     : per-drive block address / block count minus 1
//   sd_rd/sd_wr           : per-drive level requests (both set means read)
//   sd_ack                : one-hot grant, high for the whole transfer
//   sd_buff_addr/dout/wr  : byte index, read data and write strobe to the drive buffer
//   sd_buff_din           : per-drive write data, valid 1 cycle after sd_buff_addr
//   mem_addr/rd/wr/dout   : backing-store request
//   mem_din/mem_ready     : backing-store read data / completion
//   dbg_state             : current state, for observation only
//
// Store handshake: mem_rd or mem_wr rises with a stable mem_addr (and
// mem_dout for writes) and is held unchanged until the cycle in which
// mem_ready is seen high; that cycle completes the access and mem_din is
// taken in it. mem_ready while no request is raised is ignored.
module iecdrv_sd_server
    import iecdrv_pkg::*;
#(
    parameter  int DRIVES = 2,
    parameter  int ADDR_W = 32,
    localparam int NDR    = clamp_drives(DRIVES)
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NDR-1:0][31:0]   sd_lba,
    input  logic [NDR-1:0][5:0]    sd_blk_cnt,
    input  logic [NDR-1:0]         sd_rd,
    input  logic [NDR-1:0]         sd_wr,
    output logic [NDR-1:0]         sd_ack,
    output logic [15:0]            sd_buff_addr,
    output logic [7:0]             sd_buff_dout,
    input  logic [NDR-1:0][7:0]    sd_buff_din,
    output logic                   sd_buff_wr,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [7:0]             mem_dout,
    input  logic [7:0]             mem_din,
    input  logic                   mem_ready,
    output state_t                 dbg_state
);

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  drive;
    logic [31:0] lba_q;
    logic [15:0] k;
    logic [15:0] last_k;
    logic [40:0] addr_full;

    // Per-drive inputs padded to MAX_DRIVES so a 2-bit drive index selects cleanly.
    logic [MAX_DRIVES-1:0]       req_pad;
    logic [MAX_DRIVES-1:0]       rd_pad;
    logic [MAX_DRIVES-1:0][31:0] lba_pad;
    logic [MAX_DRIVES-1:0][5:0]  cnt_pad;
    logic [MAX_DRIVES-1:0][7:0]  din_pad;

    logic [1:0] arb_grant;
    logic       arb_valid;

    always_comb begin
        req_pad = '0;
        rd_pad  = '0;
        lba_pad = '0;
        cnt_pad = '0;
        din_pad = '0;
        for (int i = 0; i < NDR; i++) begin
            req_pad[i] = sd_rd[i] | sd_wr[i];
            rd_pad[i]  = sd_rd[i];
            lba_pad[i] = sd_lba[i];
            cnt_pad[i] = sd_blk_cnt[i];
            din_pad[i] = sd_buff_din[i];
        end
    end

    iecdrv_rr_arb #(.NDR(NDR)) u_arb (
        .req   (req_pad),
        .ptr   (ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Byte address of the current byte; wide enough that no carry is lost
    // before truncation to the store width.
    assign addr_full = {lba_q, 9'b0} + {25'b0, k};
    assign dbg_state = state;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            drive        <= '0;
            lba_q        <= '0;
            k            <= '0;
            last_k       <= '0;
            sd_ack       <= '0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_dout     <= '0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        drive  <= arb_grant;
                        lba_q  <= lba_pad[arb_grant];
                        last_k <= 16'((int'(cnt_pad[arb_grant]) + 1) * BLK_BYTES - 1);
                        k      <= '0;
                        ptr    <= (arb_grant == 2'(NDR - 1)) ? 2'd0 : arb_grant + 2'd1;
                        for (int i = 0; i < NDR; i++)
                            sd_ack[i] <= (arb_grant == 2'(i));
                        if (rd_pad[arb_grant]) begin
                            state <= RD_REQ;
                        end else begin
                            // Present byte 0 to the buffer so its data is ready in WR_LAT.
                            sd_buff_addr <= '0;
                            state        <= WR_ADDR;
                        end
                    end
                end
                RD_REQ: begin
                    // First cycle raises the request; completion only counts once it is up.
                    if (!mem_rd) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= addr_full[ADDR_W-1:0];
                    end else if (mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= mem_din;
                        sd_buff_addr <= k;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    if (k == last_k) begin
                        sd_ack <= '0;
                        state  <= FINISH;
                    end else begin
                        k     <= k + 16'd1;
                        state <= RD_REQ;
                    end
                end
                WR_ADDR: begin
                    sd_buff_addr <= k;
                    state        <= WR_LAT;
                end
                WR_LAT: begin
                    mem_dout <= din_pad[drive];
                    state    <= WR_REQ;
                end
                WR_REQ: begin
                    if (!mem_wr) begin
                        mem_wr   <= 1'b1;
                        mem_addr <= addr_full[ADDR_W-1:0];
                    end else if (mem_ready) begin
                        mem_wr <= 1'b0;
                        if (k == last_k) begin
                            sd_ack <= '0;
                            state  <= FINISH;
                        end else begin
                            k            <= k + 16'd1;
                            sd_buff_addr <= k + 16'd1;
                            state        <= WR_ADDR;
                        end
                    end
                end
                FINISH: begin
                    // Wait for the served drive to withdraw so a stale level
                    // request cannot restart the same transfer.
                    if (!req_pad[drive])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_sd_server.sv
module tb_iecdrv_sd_server;
    import iecdrv_pkg::*;

    localparam int NDR = 2;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic [NDR-1:0][31:0] sd_lba;
    logic [NDR-1:0][5:0]  sd_blk_cnt;
    logic [NDR-1:0]       sd_rd;
    logic [NDR-1:0]       sd_wr;
    logic [NDR-1:0]       sd_ack;
    logic [15:0]          sd_buff_addr;
    logic [7:0]           sd_buff_dout;
    logic [NDR-1:0][7:0]  sd_buff_din;
    logic                 sd_buff_wr;
    logic [31:0]          mem_addr;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [7:0]           mem_dout;
    logic [7:0]           mem_din;
    logic                 mem_ready;
    state_t               dbg_state;

    iecdrv_sd_server #(.DRIVES(2), .ADDR_W(32)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_ready    (mem_ready),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [55:0] exp_q[$];   // {store address, byte index, data}
    int          obs_cnt    = 0;
    int          byte_err   = 0;
    string       first_err  = "";
    int          wr_seen    = 0;
    int          proto_viol = 0;
    int          mem_delay  = 0;
    int          wcnt       = 0;
    logic [15:0] buf_prev   = '0;
    logic [31:0] last_rd_addr = '0;
    logic        prev_pending = 1'b0;
    logic        prev_rd      = 1'b0;
    logic [31:0] prev_addr    = '0;

    typedef struct {
        int          drive;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic [5:0]  cnt;
        int          delay;
        logic [1:0]  exp_ack;
        logic        is_read;
        int          bytes;
        logic [31:0] base;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [7:0] drive_key(input int d);
        return (d == 0) ? 8'hA5 : 8'h5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [55:0] o);
        logic [55:0] e;
        obs_cnt++;
        if (exp_q.size() == 0) begin
            if (byte_err == 0)
                first_err = $sformatf("unexpected %0h", o);
            byte_err++;
        end else begin
            e = exp_q.pop_front();
            if (e !== o) begin
                if (byte_err == 0)
                    first_err = $sformatf("got %0h want %0h", o, e);
                byte_err++;
            end
        end
    endtask

    // Memory responder, drive buffer model and protocol monitor, all on the
    // falling edge so every DUT output is settled.
    always @(negedge clk_sys) begin
        if (reset) begin
            mem_ready    = 1'b0;
            mem_din      = 8'hEE;
            wcnt         = 0;
            prev_pending = 1'b0;
        end else begin
            if (mem_rd && mem_wr)
                proto_viol++;
            if (!$onehot0(sd_ack))
                proto_viol++;
            if (prev_pending && (mem_rd !== prev_rd || mem_wr !== !prev_rd || mem_addr !== prev_addr))
                proto_viol++;

            if (sd_buff_wr)
                observe({last_rd_addr, sd_buff_addr, sd_buff_dout});

            if ((mem_rd || mem_wr) && !mem_ready) begin
                if (wcnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    mem_din   = mem_addr[7:0];
                    wcnt      = 0;
                    if (mem_rd) begin
                        last_rd_addr = mem_addr;
                    end else begin
                        observe({mem_addr, 16'(wr_seen), mem_dout});
                        wr_seen++;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_din   = 8'hEE;
            end
            prev_pending = (mem_rd || mem_wr) && !mem_ready;
            prev_rd      = mem_rd;
            prev_addr    = mem_addr;

            for (int d = 0; d < NDR; d++)
                sd_buff_din[d] = buf_prev[7:0] ^ drive_key(d);
            buf_prev = sd_buff_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_exp(input int drive, input logic is_read, input int bytes,
                            input logic [31:0] base, input int delay);
        logic [31:0] a;
        exp_q.delete();
        obs_cnt   = 0;
        byte_err  = 0;
        wr_seen   = 0;
        first_err = "";
        mem_delay = delay;
        for (int k = 0; k < bytes; k++) begin
            a = base + 32'(k);
            exp_q.push_back({a, 16'(k), is_read ? a[7:0] : (8'(k) ^ drive_key(drive))});
        end
    endtask

    task automatic wait_ack(input string name, input logic [1:0] exp_ack);
        int n = 0;
        while (sd_ack == '0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, " ack"}, 64'(sd_ack), 64'(exp_ack));
    endtask

    task automatic wait_done(input string name, input int bytes, input int delay);
        int n = 0;
        int budget = bytes * (delay + 6) + 50;
        while (sd_ack != '0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, " ack released"}, 64'(sd_ack), 64'(0));
        check({name, " byte count"}, 64'(obs_cnt), 64'(bytes));
        total++;
        if (byte_err != 0) begin
            bad++;
            $display("FAIL %s data: %0d wrong bytes, first %s", name, byte_err, first_err);
        end
        check({name, " leftover"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (dbg_state != IDLE && n < 5) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, " idle"}, 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic run_vec(input string name, input vec_t v);
        load_exp(v.drive, v.is_read, v.bytes, v.base, v.delay);
        @(negedge clk_sys);
        sd_lba[v.drive]     = v.lba;
        sd_blk_cnt[v.drive] = v.cnt;
        sd_rd[v.drive]      = v.rd;
        sd_wr[v.drive]      = v.wr;
        wait_ack(name, v.exp_ack);
        wait_done(name, v.bytes, v.delay);
        repeat (3) @(negedge clk_sys);
        check({name, " holds finish"}, 64'(dbg_state), 64'(FINISH));
        sd_rd[v.drive] = 1'b0;
        sd_wr[v.drive] = 1'b0;
        wait_idle(name);
    endtask

    task automatic pulse_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        sd_lba     = '0;
        sd_blk_cnt = '0;
        sd_rd      = '0;
        sd_wr      = '0;
        sd_buff_din = '0;
        mem_din    = 8'hEE;
        mem_ready  = 1'b0;

        vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0003, 6'd0, 0, 2'b01, 1'b1, 512,  32'h0000_0600};
        vecs[1] = '{1, 1'b0, 1'b1, 32'h0000_0010, 6'd1, 0, 2'b10, 1'b0, 1024, 32'h0000_2000};
        vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0005, 6'd0, 1, 2'b01, 1'b1, 512,  32'h0000_0A00};
        vecs[3] = '{1, 1'b1, 1'b0, 32'h0000_0007, 6'd0, 5, 2'b10, 1'b1, 512,  32'h0000_0E00};
        vecs[4] = '{0, 1'b0, 1'b1, 32'h007F_FFFF, 6'd1, 0, 2'b01, 1'b0, 1024, 32'hFFFF_FE00};

        // reset state
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("reset ack", 64'(sd_ack), 64'(0));
        check("reset mem req", 64'({mem_rd, mem_wr}), 64'(0));
        check("reset buff", 64'({sd_buff_wr, sd_buff_addr, sd_buff_dout}), 64'(0));
        check("reset mem bus", 64'({mem_addr, mem_dout}), 64'(0));
        check("reset state", 64'(dbg_state), 64'(IDLE));

        // table-driven transfers
        for (int i = 0; i < 5; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset in the middle of a read
        load_exp(0, 1'b1, 512, 32'h0000_0400, 0);
        @(negedge clk_sys);
        sd_lba[0] = 32'h2;
        sd_blk_cnt[0] = 6'd0;
        sd_rd[0] = 1'b1;
        n = 0;
        while (obs_cnt < 100 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check("midreset reached byte 100", 64'(obs_cnt), 64'(100));
        reset = 1'b1;
        sd_rd = '0;
        @(negedge clk_sys);
        check("midreset ack", 64'(sd_ack), 64'(0));
        check("midreset mem req", 64'({mem_rd, mem_wr}), 64'(0));
        check("midreset buff", 64'({sd_buff_wr, sd_buff_addr}), 64'(0));
        check("midreset state", 64'(dbg_state), 64'(IDLE));
        exp_q.delete();
        obs_cnt  = 0;
        byte_err = 0;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("midreset no writes", 64'(obs_cnt + wr_seen), 64'(0));
        run_vec("after reset", vecs[0]);

        // arbitration: both drives request with ptr back at 0
        pulse_reset();
        load_exp(0, 1'b1, 512, 32'h0000_0200, 0);
        sd_lba[0] = 32'h1;
        sd_lba[1] = 32'h2;
        sd_blk_cnt = '0;
        sd_rd = 2'b11;
        wait_ack("arb first", 2'b01);
        wait_done("arb first", 512, 0);
        load_exp(1, 1'b1, 512, 32'h0000_0400, 0);
        sd_rd[0] = 1'b0;
        @(negedge clk_sys);
        sd_rd[0] = 1'b1;
        wait_ack("arb second", 2'b10);
        wait_done("arb second", 512, 0);
        sd_rd = '0;
        wait_idle("arb second");

        check("protocol violations", 64'(proto_viol), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
